// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline stage modules and the hazard controller.
// master = pipeline side (drives hazard inputs); slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic              RegWriteM, RegWriteW, ResultSrcE, PCSrcE, IllegalOp;
  logic              MemReqM, MemReadyM;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, BubbleW;
  logic              Halted, BusErr;
  logic [CNT_W-1:0]  CycleCnt, StallCnt, FlushCnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, IllegalOp, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, BubbleW, Halted, BusErr, CycleCnt, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, IllegalOp, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, BubbleW, Halted, BusErr, CycleCnt, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use, branch flush,
// memory wait-state stall with timeout, sticky halt. Define HAZ_PERF_CNT_EN for perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int unsigned WCW = $clog2(WAIT_MAX + 1);
  localparam logic [REG_AW-1:0] RegZero = '0;

  typedef enum logic [1:0] {StRun, StMwait, StHalt} state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           bus_err_q, bus_err_d;

  logic       memwait, load_use;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w;

  assign memwait  = hz.MemReqM && !hz.MemReadyM;
  assign load_use = hz.ResultSrcE && (hz.RD_E != RegZero) &&
                    ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));

  // M-stage result is younger than W, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RD_M != RegZero) && (hz.RD_M == hz.Rs1_E)) begin
      fwd_a = 2'b10;
    end else if (hz.RegWriteW && (hz.RD_W != RegZero) && (hz.RD_W == hz.Rs1_E)) begin
      fwd_a = 2'b01;
    end
    if (hz.RegWriteM && (hz.RD_M != RegZero) && (hz.RD_M == hz.Rs2_E)) begin
      fwd_b = 2'b10;
    end else if (hz.RegWriteW && (hz.RD_W != RegZero) && (hz.RD_W == hz.Rs2_E)) begin
      fwd_b = 2'b01;
    end
    if (!rst) begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end
  end

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_w = 1'b0;
    if ((state_q == StHalt) || memwait) begin
      // Freeze F..M and bubble W so the stalled M instruction is not written back twice.
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
    if (!rst) begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      bubble_w = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      StRun: begin
        if (memwait) begin
          state_d    = StMwait;
          wait_cnt_d = WCW'(1);
        end else if (hz.IllegalOp && !hz.PCSrcE && !load_use) begin
          state_d = StHalt;
        end
      end
      StMwait: begin
        if (hz.MemReadyM) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(WAIT_MAX)) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.BubbleW   = bubble_w;
  assign hz.Halted    = (state_q == StHalt);
  assign hz.BusErr    = bus_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

  // Cycle count keeps running in HALT so software can time the hang.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (state_q != StHalt) begin
        if (stall_f) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        if (flush_e) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign hz.CycleCnt = cycle_cnt_q;
  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.CycleCnt = {CNT_W{1'b0}};
  assign hz.StallCnt = {CNT_W{1'b0}};
  assign hz.FlushCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Second-generation hazard controller for the 5-stage RV32I pipeline. It replaces forward-only control with full hazard resolution: M/W forwarding, load-use stall, taken-branch flush, data-memory wait-state stall with timeout, and a sticky halt on illegal opcodes. It sits beside the stage modules in the pipeline top and drives every stage register's stall/flush enable.

## Interface
- REG_AW, 5, register-address width
- WAIT_MAX, 16, max consecutive memory-wait cycles before bus-error halt (≥1)
- CNT_W, 32, performance-counter width (used only with HAZ_PERF_CNT_EN)

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- Rs1_D, Rs2_D  in  REG_AW  source registers in Decode
- Rs1_E, Rs2_E, RD_E  in  REG_AW  sources/destination in Execute
- RD_M, RD_W  in  REG_AW  destinations in Memory/Writeback
- RegWriteM, RegWriteW  in  1  register write enables in M/W
- ResultSrcE  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- IllegalOp  in  1  Decode holds an illegal opcode
- MemReqM, MemReadyM  in  1  data-memory request / ready in Memory
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALU_ResultM
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE  out  1  load bubble into D/E register
- BubbleW  out  1  load bubble into W register
- Halted, BusErr  out  1  sticky halt; halt cause is memory timeout
- CycleCnt, StallCnt, FlushCnt  out  CNT_W  perf counters (macro-gated)

## Operation
- Forwarding (combinational, all states): ForwardAE=10 if RegWriteM && RD_M!=0 && RD_M==Rs1_E; else 01 if RegWriteW && RD_W!=0 && RD_W==Rs1_E; else 00. ForwardBE identical using Rs2_E. M beats W.
- memwait = MemReqM && !MemReadyM, in RUN or MWAIT.
- Priority, highest first: HALT > memwait > PCSrcE > load-use.
  - HALT: StallF/D/E/M=1, BubbleW=1, flushes 0.
  - memwait: StallF/D/E/M=1, BubbleW=1 (no duplicate write-back), flushes 0; a pending branch/load-use is evaluated after the wait.
  - PCSrcE: FlushD=1, FlushE=1, StallF=0 (PC loads target).
  - load-use (ResultSrcE && RD_E!=0 && (RD_E==Rs1_D || RD_E==Rs2_D)): StallF=1, StallD=1, FlushE=1.
- FSM states RUN, MWAIT, HALT; state, WaitCnt, Halted, BusErr registered.
  - RUN→MWAIT: memwait; WaitCnt←1.
  - MWAIT: MemReadyM→RUN, WaitCnt←0; else WaitCnt←WaitCnt+1; if WaitCnt==WAIT_MAX and !MemReadyM → HALT, BusErr←1.
  - RUN→HALT: IllegalOp && !PCSrcE && !memwait && !load-use (flushed/stalled illegal ops are ignored).
  - HALT: absorbing until rst; Halted=1. Halt is imprecise: E/M contents frozen, not retired.
- WaitCnt width: clog2(WAIT_MAX+1).

## Timing
- Forward/stall/flush/bubble outputs: combinational, same cycle as inputs.
- Halted/BusErr rise the cycle after the triggering edge.
- memwait stall covers the first not-ready cycle with zero latency; stall drops in the cycle MemReadyM is high.
- WAIT_MAX=N: N consecutive stalled cycles permitted; HALT entered at the edge ending cycle N+1 if still not ready.
- Reset (asserted low, any time incl. mid-wait): state RUN, WaitCnt 0, Halted 0, BusErr 0, counters 0; while rst low all stall/flush/bubble/forward outputs forced 0.

## Configuration
- HAZ_PERF_CNT_EN defined: CycleCnt increments every non-reset cycle; StallCnt increments each cycle StallF=1; FlushCnt increments each cycle FlushE=1; all wrap at 2^CNT_W; frozen in HALT except CycleCnt.
- Undefined: counters not instantiated, the three outputs tied to 0.

## Test plan
- RD_M=5, RegWriteM=1, Rs1_E=5, RD_W=5, RegWriteW=1 -> ForwardAE=10; RD_M=0 instead -> ForwardAE=01; Rs2_E=5 mirrors on ForwardBE.
- Load x3 in E (ResultSrcE=1, RD_E=3), Rs2_D=3 -> StallF=StallD=FlushE=1 for one cycle; RD_E=0 -> no stall.
- PCSrcE=1 together with load-use -> FlushD=FlushE=1, StallF=0; with memwait also high -> only stalls, BubbleW=1.
- WAIT_MAX=4, MemReqM=1, MemReadyM held 0 -> 5 stalled cycles, then Halted=BusErr=1; ready on 3rd cycle instead -> return to RUN, no halt.
- IllegalOp=1 in RUN -> Halted=1 next cycle, all stalls 1; same with PCSrcE=1 -> no halt; rst low mid-halt -> all outputs 0.
- With HAZ_PERF_CNT_EN: 10 cycles containing 2 load-use and 1 branch -> CycleCnt=10, StallCnt=2, FlushCnt=3.
